// File: rtl/uv_uart_pkg.sv
// Shared UART definitions: FSM state and parity encodings, plus the data-width rule
// used by both uv_uart_tx and uv_uart_rx.
package uv_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP0  = 3'd4,
        ST_STOP1  = 3'd5
    } uart_state_e;

    typedef enum logic [1:0] {
        PAR_SPACE = 2'b00,
        PAR_MARK  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_EVEN  = 2'b11
    } parity_e;

    function automatic logic [3:0] data_nbits(input logic [1:0] nbits);
        return {2'b00, nbits} + 4'd5;
    endfunction

endpackage

// File: rtl/uv_uart_baud_cnt.sv
// Bit-period counter: runs 0..clk_div-1 while enabled, flags the wrap and the mid-bit sample point.
module uv_uart_baud_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] clk_div,
    output logic        cnt_end,
    output logic        cnt_half
);

    logic [15:0] cnt;
    logic [16:0] cnt_inc;

    assign cnt_inc  = {1'b0, cnt} + 17'd1;
    assign cnt_end  = en & (cnt_inc == {1'b0, clk_div});
    assign cnt_half = en & (cnt_inc == {2'b00, clk_div[15:1]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uv_uart_rx.sv
// UART receiver: synchronises the line, frames one character with parity/stop checking
// and presents it on a vld/rdy interface with overflow indication.
module uv_uart_rx
    import uv_uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic        rx_en,
    input  logic [1:0]  nbits,
    input  logic        nstop,
    input  logic        endian,
    input  logic [15:0] clk_div,
    input  logic        parity_en,
    input  logic [1:0]  parity_type,
    output logic        rx_vld,
    input  logic        rx_rdy,
    output logic [7:0]  rx_dat,
    output logic        rx_perr,
    output logic        rx_ferr,
    output logic        rx_ovf
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   line;
    logic                   line_d;

    uart_state_e state, state_next;
    logic        start_det;
    logic        baud_en;
    logic        cnt_end;
    logic        cnt_half;

    logic [3:0]  nb;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic        par_bit;
    logic        ferr_acc;

    logic        frame_done;
    logic        done_ferr;
    logic [7:0]  word_raw;
    logic [7:0]  word;
    logic        par_exp;
    logic        frame_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '1;
            line_d <= 1'b1;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], uart_rx};
            line_d <= line;
        end
    end

    assign line      = sync[SYNC_STAGES-1];
    assign nb        = data_nbits(nbits);
    assign start_det = rx_en & (state == ST_IDLE) & line_d & ~line;
    assign baud_en   = (state != ST_IDLE);

    uv_uart_baud_cnt u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (baud_en),
        .clr      (start_det),
        .clk_div  (clk_div),
        .cnt_end  (cnt_end),
        .cnt_half (cnt_half)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        done_ferr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_det) state_next = ST_START;
            end
            ST_START: begin
                if (cnt_half && line) state_next = ST_IDLE;
                else if (cnt_end)     state_next = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_end && (bit_cnt >= nb))
                    state_next = parity_en ? ST_PARITY : ST_STOP0;
            end
            ST_PARITY: begin
                if (cnt_end) state_next = ST_STOP0;
            end
            ST_STOP0: begin
                // Single stop bit completes at mid-bit so a back-to-back start edge is not missed
                if (!nstop) begin
                    if (cnt_half) begin
                        frame_done = 1'b1;
                        done_ferr  = ~line;
                        state_next = ST_IDLE;
                    end
                end else if (cnt_end) begin
                    state_next = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (cnt_half) begin
                    frame_done = 1'b1;
                    done_ferr  = ferr_acc | ~line;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!rx_en) begin
            state_next = ST_IDLE;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            if (start_det) begin
                bit_cnt  <= '0;
                shift    <= '0;
                par_bit  <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (cnt_half) begin
                case (state)
                    ST_DATA: begin
                        shift   <= {line, shift[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    ST_PARITY: par_bit  <= line;
                    ST_STOP0:  ferr_acc <= ~line;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        logic [3:0] idx;
        word_raw = shift >> (4'd8 - nb);
        word     = word_raw;
        idx      = '0;
        if (endian) begin
            word = '0;
            for (int unsigned i = 0; i < 8; i++) begin
                if (4'(i) < nb) begin
                    idx     = nb - 4'd1 - 4'(i);
                    word[i] = word_raw[idx[2:0]];
                end
            end
        end
        case (parity_e'(parity_type))
            PAR_SPACE: par_exp = 1'b0;
            PAR_MARK:  par_exp = 1'b1;
            PAR_ODD:   par_exp = ~^word;
            PAR_EVEN:  par_exp = ^word;
            default:   par_exp = 1'b0;
        endcase
        frame_perr = parity_en & (par_bit != par_exp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_vld  <= 1'b0;
            rx_dat  <= '0;
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
            rx_ovf  <= 1'b0;
        end else begin
            rx_ovf <= 1'b0;
            if (frame_done) begin
                if (!rx_vld || rx_rdy) begin
                    rx_vld  <= 1'b1;
                    rx_dat  <= word;
                    rx_perr <= frame_perr;
                    rx_ferr <= done_ferr;
                end else begin
                    rx_ovf <= 1'b1;
                end
            end else if (rx_vld && rx_rdy) begin
                rx_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uv_uart_rx.sv
// Directed bench for uv_uart_rx: a table of framed characters plus hand-written
// sequences for glitch rejection, overflow, receiver disable and mid-frame reset.
module tb_uv_uart_rx;
    import uv_uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic        rx_en;
    logic [1:0]  nbits;
    logic        nstop;
    logic        endian;
    logic [15:0] clk_div;
    logic        parity_en;
    logic [1:0]  parity_type;
    logic        rx_vld;
    logic        rx_rdy;
    logic [7:0]  rx_dat;
    logic        rx_perr;
    logic        rx_ferr;
    logic        rx_ovf;

    uv_uart_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .rx_en       (rx_en),
        .nbits       (nbits),
        .nstop       (nstop),
        .endian      (endian),
        .clk_div     (clk_div),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .rx_vld      (rx_vld),
        .rx_rdy      (rx_rdy),
        .rx_dat      (rx_dat),
        .rx_perr     (rx_perr),
        .rx_ferr     (rx_ferr),
        .rx_ovf      (rx_ovf)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    int          div = 16;
    logic [9:0]  cap_q[$];
    int          ovf_cnt = 0;
    int unsigned rise_cyc = 0;
    int unsigned start_cyc = 0;
    logic        vld_prev = 1'b0;

    // Accepted words as {dat, perr, ferr}
    always @(negedge clk) begin
        if (rx_vld && rx_rdy) cap_q.push_back({rx_dat, rx_perr, rx_ferr});
        if (rx_ovf) ovf_cnt++;
        if (rx_vld && !vld_prev) rise_cyc = cyc;
        vld_prev = rx_vld;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] nbc, input logic msb_first,
                              input logic pen, input logic pbit, input logic two_stop,
                              input logic s0, input logic s1);
        int nb;
        nb = int'(nbc) + 5;
        @(negedge clk);
        uart_rx   = 1'b0;
        start_cyc = cyc;
        repeat (div) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            uart_rx = msb_first ? d[nb-1-i] : d[i];
            repeat (div) @(negedge clk);
        end
        if (pen) begin
            uart_rx = pbit;
            repeat (div) @(negedge clk);
        end
        uart_rx = s0;
        repeat (div) @(negedge clk);
        if (two_stop) begin
            uart_rx = s1;
            repeat (div) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic set_8n1();
        div = 16; clk_div = 16'd16; nbits = 2'd3; nstop = 1'b0;
        endian = 1'b0; parity_en = 1'b0; parity_type = PAR_SPACE;
    endtask

    typedef struct {
        int         div;
        logic [7:0] data;
        logic [1:0] nbits;
        logic       nstop;
        logic       endian;
        logic       pen;
        logic [1:0] ptype;
        logic       pbit;
        logic       s0;
        logic       s1;
        logic [7:0] edat;
        logic       eperr;
        logic       eferr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{16, 8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, PAR_SPACE, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{16, 8'h35, 2'd2, 1'b0, 1'b1, 1'b1, PAR_EVEN,  1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0};
        vecs[2]  = '{16, 8'h1F, 2'd0, 1'b0, 1'b0, 1'b0, PAR_SPACE, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
        vecs[3]  = '{16, 8'h0F, 2'd3, 1'b0, 1'b0, 1'b1, PAR_ODD,   1'b1, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
        vecs[4]  = '{16, 8'h0F, 2'd3, 1'b0, 1'b0, 1'b1, PAR_ODD,   1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[5]  = '{16, 8'hA5, 2'd3, 1'b1, 1'b0, 1'b0, PAR_SPACE, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[6]  = '{16, 8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, PAR_SPACE, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[7]  = '{16, 8'h2A, 2'd1, 1'b0, 1'b0, 1'b1, PAR_MARK,  1'b0, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0};
        vecs[8]  = '{16, 8'h2A, 2'd1, 1'b0, 1'b0, 1'b1, PAR_SPACE, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
        vecs[9]  = '{4,  8'hC3, 2'd3, 1'b0, 1'b1, 1'b1, PAR_EVEN,  1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[10] = '{5,  8'h5A, 2'd2, 1'b1, 1'b0, 1'b1, PAR_EVEN,  1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
        vecs[11] = '{16, 8'h12, 2'd0, 1'b0, 1'b1, 1'b1, PAR_ODD,   1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0};

        rst = 1'b1; uart_rx = 1'b1; rx_en = 1'b1; rx_rdy = 1'b1;
        set_8n1();
        repeat (3) @(negedge clk);
        check("reset_vld",  32'(rx_vld),  32'd0);
        check("reset_dat",  32'(rx_dat),  32'd0);
        check("reset_perr", 32'(rx_perr), 32'd0);
        check("reset_ferr", 32'(rx_ferr), 32'd0);
        check("reset_ovf",  32'(rx_ovf),  32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int r = 0; r < 12; r++) begin
            div = vecs[r].div; clk_div = 16'(vecs[r].div);
            nbits = vecs[r].nbits; nstop = vecs[r].nstop; endian = vecs[r].endian;
            parity_en = vecs[r].pen; parity_type = vecs[r].ptype;
            cap_q.delete();
            send_frame(vecs[r].data, vecs[r].nbits, vecs[r].endian, vecs[r].pen, vecs[r].pbit,
                       vecs[r].nstop, vecs[r].s0, vecs[r].s1);
            repeat (3 * div) @(negedge clk);
            if (r == 0) check("vld_latency_8n1", rise_cyc - start_cyc, 32'd155);
            check($sformatf("vec%0d_count", r), cap_q.size(), 32'd1);
            if (cap_q.size() > 0) begin
                check($sformatf("vec%0d_dat", r),  32'(cap_q[0][9:2]), 32'(vecs[r].edat));
                check($sformatf("vec%0d_perr", r), 32'(cap_q[0][1]),   32'(vecs[r].eperr));
                check($sformatf("vec%0d_ferr", r), 32'(cap_q[0][0]),   32'(vecs[r].eferr));
            end
            check($sformatf("vec%0d_vld_clear", r), 32'(rx_vld), 32'd0);
        end

        // Short low glitch must be rejected as a false start
        set_8n1();
        cap_q.delete();
        @(negedge clk); uart_rx = 1'b0;
        repeat (4) @(negedge clk); uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_word", cap_q.size(), 32'd0);
        check("glitch_no_vld", 32'(rx_vld), 32'd0);
        send_frame(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (48) @(negedge clk);
        check("after_glitch_count", cap_q.size(), 32'd1);
        if (cap_q.size() > 0) check("after_glitch_dat", 32'(cap_q[0][9:2]), 32'h55);

        // Overflow: second frame dropped while first is held
        begin
            int ovf0;
            cap_q.delete();
            ovf0 = ovf_cnt;
            rx_rdy = 1'b0;
            send_frame(8'h11, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            send_frame(8'h22, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            repeat (40) @(negedge clk);
            check("ovf_vld_held", 32'(rx_vld), 32'd1);
            check("ovf_dat_held", 32'(rx_dat), 32'h11);
            check("ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
            check("ovf_no_transfer", cap_q.size(), 32'd0);
            @(posedge clk); #1 rx_rdy = 1'b1;
            @(posedge clk); #1 rx_rdy = 1'b0;
            repeat (3) @(negedge clk);
            check("ovf_accept_count", cap_q.size(), 32'd1);
            if (cap_q.size() > 0) check("ovf_accept_dat", 32'(cap_q[0][9:2]), 32'h11);
            check("ovf_vld_cleared", 32'(rx_vld), 32'd0);
            rx_rdy = 1'b1;
        end

        // Disabling the receiver mid-frame discards the partial word
        cap_q.delete();
        fork
            send_frame(8'h99, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                repeat (60) @(negedge clk);
                rx_en = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        rx_en = 1'b1;
        repeat (20) @(negedge clk);
        check("rx_en_discard", cap_q.size(), 32'd0);

        // Async reset in the middle of DATA
        cap_q.delete();
        @(negedge clk); uart_rx = 1'b0;
        repeat (16 + 16 * 3 + 8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_vld", 32'(rx_vld), 32'd0);
        check("midrst_dat", 32'(rx_dat), 32'd0);
        check("midrst_ferr", 32'(rx_ferr), 32'd0);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (48) @(negedge clk);
        check("after_rst_count", cap_q.size(), 32'd1);
        if (cap_q.size() > 0) begin
            check("after_rst_dat",  32'(cap_q[0][9:2]), 32'h3C);
            check("after_rst_ferr", 32'(cap_q[0][0]),   32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
